// File: rtl/cart_rom_loader.sv
// cart_rom_loader
//   Bridges the hps_io ioctl download stream to the SDRAM write port. Each
//   ioctl byte becomes one toggle-handshake SDRAM write. ioctl_wait holds
//   off hps_io while a write is outstanding. When the download ends, the
//   bank mask (cart_sz) and console type (gg) are published to the mapper.
//
//   Optional feature: define HEADER_STRIP_EN to add the hdr_skip input.
//   hdr_skip is sampled at the download rise. When it is 1, the first 512
//   bytes are consumed silently and excluded from the byte count.
//
// Ports
//   clk_sys         system clock
//   reset           synchronous, active-high (power/PLL reset)
//   ioctl_download  download window active
//   ioctl_wr        one-cycle byte strobe
//   ioctl_dout      byte data
//   ioctl_index     file slot (2 = Game Gear)
//   hdr_skip        strip a 512-byte header (HEADER_STRIP_EN only)
//   ioctl_wait      hold-off to hps_io
//   mem_waddr       SDRAM byte address
//   mem_din         SDRAM write data
//   mem_we          write request (toggle)
//   mem_we_ack      write acknowledge (toggle; done when equal to mem_we)
//   cart_sz         bank mask, 2^n-1
//   gg              latched ioctl_index==2
//   overflow        sticky: bytes beyond the ROM limit were dropped
//   busy            FSM not idle
//   load_done       one-cycle pulse once a load is committed
module cart_rom_loader #(
  parameter int ADDR_W   = 24,
  parameter int BANK_LSB = 14,
  parameter int SZ_W     = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
`ifdef HEADER_STRIP_EN
  input  logic              hdr_skip,
`endif
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic              mem_we_ack,
  output logic [SZ_W-1:0]   cart_sz,
  output logic              gg,
  output logic              overflow,
  output logic              busy,
  output logic              load_done
);

  localparam longint unsigned LIMIT = 64'd1 << (BANK_LSB + SZ_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            state, state_next;
  logic              dl_q;
  logic              dl_rise;
  logic [ADDR_W-1:0] counter;
  logic              gg_pend;
  logic              at_limit;
  logic              skip_active;
  logic              start_write;
  logic              ack_done;
  logic              skip_byte;
  logic              ovf_byte;
  logic              finish;

`ifdef HEADER_STRIP_EN
  logic [9:0] skip_cnt;
  always_comb skip_active = (skip_cnt != '0);
`else
  always_comb skip_active = 1'b0;
`endif

  always_comb dl_rise  = ioctl_download & ~dl_q;
  always_comb at_limit = (64'(counter) >= LIMIT);

  // Round the highest bank index up to the next 2^n-1 by smearing its MSB
  // into every lower bit.
  function automatic logic [SZ_W-1:0] bank_mask(input logic [ADDR_W-1:0] len);
    logic [ADDR_W-1:0] last;
    logic [SZ_W-1:0]   m;
    if (len == '0) return '0;
    last = (len - ADDR_W'(1)) >> BANK_LSB;
    m    = last[SZ_W-1:0];
    for (int unsigned i = 1; i < SZ_W; i++) m = m | (m >> i);
    return m;
  endfunction

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_write = 1'b0;
    ack_done    = 1'b0;
    skip_byte   = 1'b0;
    ovf_byte    = 1'b0;
    finish      = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (dl_rise) state_next = ARMED;
      end
      ARMED: begin
        if (dl_rise) begin
          state_next = ARMED;
        end else begin
          if (ioctl_wr) begin
            if (skip_active)   skip_byte = 1'b1;
            else if (at_limit) ovf_byte  = 1'b1;
            else begin
              start_write = 1'b1;
              state_next  = WRITE;
            end
          end
          if (!start_write && !ioctl_download) state_next = FINISH;
        end
      end
      WRITE: begin
        // A restart while waiting keeps the write pending; only the ack
        // may release ioctl_wait.
        if (mem_we == mem_we_ack) begin
          ack_done   = 1'b1;
          state_next = ioctl_download ? ARMED : FINISH;
        end
      end
      FINISH: begin
        if (dl_rise) state_next = ARMED;
        else begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q       <= 1'b0;
      ioctl_wait <= 1'b0;
      mem_we     <= mem_we_ack;
      mem_waddr  <= '0;
      mem_din    <= '0;
      cart_sz    <= '0;
      gg         <= 1'b0;
      gg_pend    <= 1'b0;
      overflow   <= 1'b0;
      load_done  <= 1'b0;
      counter    <= '0;
`ifdef HEADER_STRIP_EN
      skip_cnt   <= '0;
`endif
    end else begin
      dl_q      <= ioctl_download;
      load_done <= 1'b0;

      if (dl_rise) begin
        counter  <= '0;
        overflow <= 1'b0;
        gg_pend  <= (ioctl_index == 8'd2);
`ifdef HEADER_STRIP_EN
        skip_cnt <= hdr_skip ? 10'd512 : 10'd0;
`endif
      end else if (ack_done) begin
        counter <= counter + ADDR_W'(1);
      end

      if (start_write) begin
        mem_din    <= ioctl_dout;
        mem_waddr  <= counter;
        mem_we     <= ~mem_we;
        ioctl_wait <= 1'b1;
      end

      if (ack_done) ioctl_wait <= 1'b0;

`ifdef HEADER_STRIP_EN
      if (skip_byte) skip_cnt <= skip_cnt - 10'd1;
`endif

      if (ovf_byte) overflow <= 1'b1;

      if (finish) begin
        cart_sz   <= overflow ? '1 : bank_mask(counter);
        gg        <= gg_pend;
        load_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cart_rom_loader.sv
module tb_cart_rom_loader;

  localparam int ADDR_W   = 16;
  localparam int BANK_LSB = 6;
  localparam int SZ_W     = 4;
  localparam int LIMIT    = 1 << (BANK_LSB + SZ_W);

`ifdef HEADER_STRIP_EN
  localparam bit HAS_STRIP = 1'b1;
  logic hdr_skip = 1'b0;
`else
  localparam bit HAS_STRIP = 1'b0;
`endif

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [7:0]        ioctl_dout = '0;
  logic [7:0]        ioctl_index = '0;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic              mem_we_ack = 1'b1;
  logic [SZ_W-1:0]   cart_sz;
  logic              gg;
  logic              overflow;
  logic              busy;
  logic              load_done;

  always #5 clk_sys = ~clk_sys;

  cart_rom_loader #(.ADDR_W(ADDR_W), .BANK_LSB(BANK_LSB), .SZ_W(SZ_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
`ifdef HEADER_STRIP_EN
    .hdr_skip(hdr_skip),
`endif
    .ioctl_wait(ioctl_wait), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_we_ack(mem_we_ack), .cart_sz(cart_sz), .gg(gg),
    .overflow(overflow), .busy(busy), .load_done(load_done)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  typedef struct {
    int idx;
    int nbytes;
    int ack_dly;
    bit skip;
    int exp_sz;
    bit exp_gg;
    bit exp_ovf;
  } vec_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  writes = 0;
  int  dones = 0;
  int  ack_delay = 0;
  int  exp_cnt = 0;
  int  skip_left = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired", name);
  endtask

  // SDRAM model: answers a toggle ack_delay cycles after it appears.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk_sys);
      if (mem_we !== mem_we_ack) begin
        if (cnt >= ack_delay) begin
          mem_we_ack = mem_we;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Write monitor / scoreboard consumer.
  initial begin
    logic prev_we = 1'b0;
    wr_t  e;
    forever begin
      @(negedge clk_sys);
      if (reset) prev_we = mem_we;
      else begin
        if (mem_we !== prev_we) begin
          writes++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_waddr, mem_din);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", mem_waddr, e.addr);
            check("wr_data", mem_din, e.data);
          end
          prev_we = mem_we;
        end
        if (load_done) dones++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic start_dl(input int idx, input bit skip);
    ioctl_index = 8'(idx);
`ifdef HEADER_STRIP_EN
    hdr_skip = skip;
`endif
    ioctl_download = 1'b1;
    exp_cnt = 0;
    skip_left = (skip && HAS_STRIP) ? 512 : 0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ioctl_wait && n < 3000) begin
      tick();
      n++;
    end
    if (ioctl_wait) fail_now("wait_release");
  endtask

  // Pulse one byte; the write is expected only outside the header and limit.
  task automatic pulse_byte(input logic [7:0] d);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    if (skip_left > 0) skip_left--;
    else if (exp_cnt < LIMIT) begin
      exp_q.push_back('{addr: ADDR_W'(exp_cnt), data: d});
      exp_cnt++;
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!load_done && n < 100) begin
      tick();
      n++;
    end
    if (!load_done) fail_now("load_done");
    tick();
  endtask

  task automatic run_load(input vec_t v);
    int w0, d0;
    ack_delay = v.ack_dly;
    w0 = writes;
    d0 = dones;
    start_dl(v.idx, v.skip);
    for (int i = 0; i < v.nbytes; i++) begin
      pulse_byte(8'($urandom_range(0, 255)));
      wait_idle();
    end
    ioctl_download = 1'b0;
    wait_done();
    check("cart_sz", cart_sz, v.exp_sz);
    check("gg", gg, v.exp_gg);
    check("overflow", overflow, v.exp_ovf);
    check("busy_end", busy, 0);
    check("write_count", writes - w0, exp_cnt);
    check("done_pulses", dones - d0, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  vec_t tbl[10];

  initial begin
    int d0, w0, n;
    tbl[0] = '{idx: 1, nbytes: 128,  ack_dly: 3, skip: 0, exp_sz: 1,  exp_gg: 0, exp_ovf: 0};
    tbl[1] = '{idx: 2, nbytes: 192,  ack_dly: 0, skip: 0, exp_sz: 3,  exp_gg: 1, exp_ovf: 0};
    tbl[2] = '{idx: 1, nbytes: 1,    ack_dly: 0, skip: 0, exp_sz: 0,  exp_gg: 0, exp_ovf: 0};
    tbl[3] = '{idx: 2, nbytes: 0,    ack_dly: 0, skip: 0, exp_sz: 0,  exp_gg: 1, exp_ovf: 0};
    tbl[4] = '{idx: 1, nbytes: 65,   ack_dly: 2, skip: 0, exp_sz: 1,  exp_gg: 0, exp_ovf: 0};
    tbl[5] = '{idx: 1, nbytes: 256,  ack_dly: 0, skip: 0, exp_sz: 3,  exp_gg: 0, exp_ovf: 0};
    tbl[6] = '{idx: 3, nbytes: 513,  ack_dly: 1, skip: 0, exp_sz: 15, exp_gg: 0, exp_ovf: 0};
    tbl[7] = '{idx: 1, nbytes: 1024, ack_dly: 0, skip: 0, exp_sz: 15, exp_gg: 0, exp_ovf: 0};
    tbl[8] = '{idx: 2, nbytes: 1025, ack_dly: 1, skip: 0, exp_sz: 15, exp_gg: 1, exp_ovf: 1};
    tbl[9] = '{idx: 1, nbytes: 576,  ack_dly: 0, skip: 1, exp_sz: 0,  exp_gg: 0, exp_ovf: 0};

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_wait", ioctl_wait, 0);
    check("rst_we_eq_ack", mem_we == mem_we_ack, 1);
    check("rst_waddr", mem_waddr, 0);
    check("rst_din", mem_din, 0);
    check("rst_cart_sz", cart_sz, 0);
    check("rst_gg", gg, 0);
    check("rst_overflow", overflow, 0);
    check("rst_load_done", load_done, 0);
    check("rst_busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].skip && !HAS_STRIP) continue;
      run_load(tbl[i]);
    end

    // Download falls while a write waits on a slow ack.
    ack_delay = 10;
    d0 = dones;
    start_dl(1, 1'b0);
    pulse_byte(8'hA5);
    ioctl_download = 1'b0;
    n = 0;
    while (mem_we !== mem_we_ack && n < 100) begin
      check("fall_wait_held", ioctl_wait, 1);
      check("fall_no_early_done", dones - d0, 0);
      tick();
      n++;
    end
    if (mem_we !== mem_we_ack) fail_now("fall_ack");
    wait_done();
    check("fall_done_pulses", dones - d0, 1);
    check("fall_cart_sz", cart_sz, 0);

    // Strobe while ioctl_wait is high must be ignored.
    ack_delay = 5;
    w0 = writes;
    start_dl(1, 1'b0);
    pulse_byte(8'h11);
    check("ign_wait_high", ioctl_wait, 1);
    ioctl_dout = 8'h99;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    wait_idle();
    pulse_byte(8'h22);
    wait_idle();
    ioctl_download = 1'b0;
    wait_done();
    check("ign_write_count", writes - w0, 2);
    check("ign_queue_empty", exp_q.size(), 0);

    // Reset while a write is outstanding.
    ack_delay = 1000;
    start_dl(2, 1'b0);
    pulse_byte(8'h5A);
    check("rstw_wait_high", ioctl_wait, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    check("rstw_wait", ioctl_wait, 0);
    check("rstw_we_eq_ack", mem_we == mem_we_ack, 1);
    check("rstw_busy", busy, 0);
    tick();
    reset = 1'b0;
    ack_delay = 0;
    tick();
    run_load('{idx: 1, nbytes: 64, ack_dly: 0, skip: 0, exp_sz: 0, exp_gg: 0, exp_ovf: 0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
